uart_recv: RTL and testbench

UART receiver for the off-chip serial link: recovers 7-bit frames (start, 7 data bits LSB first, 1 parity bit, 1 stop bit) from the asynchronous `rx` line and presents each word with a one-cycle valid strobe plus parity and framing error flags. It is the receiving end of the team's UART transmitter and shares its frame format and `p_sel` parity convention. It oversamples the line with an internally generated tick and samples each bit at mid-bit.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_os_tick.sv | 34 +++
 rtl/uart_recv.sv | 141 ++++++++++++++
 tb/tb_uart_recv.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART link: frame size, receiver state encoding
// and the parity convention used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // p_sel=1 selects even parity (bit equals ^data), p_sel=0 selects odd.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                      input logic                 p_sel);
    return p_sel ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-clk pulse every FRE/(BAUD_RATE*OVERSAMPLE)
// clocks, giving OVERSAMPLE ticks per bit period.
module uart_os_tick #(
  parameter int FRE        = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  output logic os_tick
);

  localparam int DIV = FRE / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      os_tick <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      os_tick <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      os_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_recv.sv
// UART receiver: 7 data bits LSB first, one parity bit, one stop bit.
// Oversamples the synchronized line and samples each bit at mid-bit.
module uart_recv
  import uart_pkg::*;
#(
  parameter int FRE        = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 p_sel,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  logic                 os_tick;
  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_s;

  uart_os_tick #(
    .FRE        (FRE),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_os_tick (
    .clk     (clk),
    .reset   (reset),
    .os_tick (os_tick)
  );

  // Both flops reset high so the idle line never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_s      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (os_tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
              busy     <= 1'b1;
            end
          end

          // A line that is high again at mid start bit was only a glitch.
          START: begin
            if (tick_cnt == TICK_MID) begin
              if (!rx_s) begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          DATA: begin
            if (tick_cnt == TICK_LAST) begin
              shift    <= {rx_s, shift[DATA_BITS-1:1]};
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == BIT_LAST) state <= PARITY;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          PARITY: begin
            if (tick_cnt == TICK_LAST) begin
              par_s    <= rx_s;
              tick_cnt <= '0;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          // Leaving at the stop-bit midpoint lets a start bit follow with no gap.
          STOP: begin
            if (tick_cnt == TICK_LAST) begin
              data_out   <= shift;
              parity_err <= (par_s != parity_bit(shift, p_sel));
              frame_err  <= ~rx_s;
              data_valid <= 1'b1;
              tick_cnt   <= '0;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv: frames are driven bit by bit, expected
// results are queued at send time and compared when the strobe appears.
module tb_uart_recv;

  localparam int FRE        = 1_600_000;
  localparam int BAUD_RATE  = 10_000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLK    = 160;

  typedef struct packed {
    logic [6:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       p_sel;
  logic [6:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   strobe_cnt = 0;
  int   frames_sent = 0;
  exp_t last_exp;

  uart_recv #(
    .FRE        (FRE),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .p_sel      (p_sel),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) strobe_cnt <= strobe_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic good_par(input logic [6:0] d, input logic ps);
    return ps ? ^d : ~^d;
  endfunction

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Sends one full frame and watches the stop bit for exactly one strobe.
  task automatic send_frame(input string name, input logic [6:0] d,
                            input logic par, input logic stop);
    int   seen;
    exp_t e;
    exp_t got;
    e.data = d;
    e.perr = (par != good_par(d, p_sel));
    e.ferr = ~stop;
    exp_q.push_back(e);
    last_exp = e;
    frames_sent++;
    drive_bit(1'b0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy: got %b, required 1", name, busy);
    end
    for (int i = 0; i < 7; i++) drive_bit(d[i]);
    drive_bit(par);
    rx   = stop;
    seen = 0;
    for (int i = 0; i < BIT_CLK; i++) begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        seen++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s strobe: got unexpected strobe, required none", name);
        end else begin
          e   = exp_q.pop_front();
          got = '{data_out, parity_err, frame_err};
          if (got !== e) begin
            n_fail++;
            $display("FAIL %s result: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                     name, data_out, parity_err, frame_err, e.data, e.perr, e.ferr);
          end
        end
      end
    end
    n_checks++;
    if (seen != 1) begin
      n_fail++;
      $display("FAIL %s strobe_cycles: got %0d, required 1", name, seen);
    end
  endtask

  task automatic check_quiet(input string name);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy: got %b, required 0", name, busy);
    end
    n_checks++;
    if (strobe_cnt != frames_sent) begin
      n_fail++;
      $display("FAIL %s strobe_count: got %0d, required %0d", name, strobe_cnt, frames_sent);
    end
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if ({data_out, data_valid, parity_err, frame_err, busy} !== 11'd0) begin
      n_fail++;
      $display("FAIL %s outputs: got data=%h dv=%b perr=%b ferr=%b busy=%b, required all 0",
               name, data_out, data_valid, parity_err, frame_err, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx    = 1'b1;
    p_sel = 1'b1;
    #1;
    check_zero("reset");
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_zero("reset_idle");
  endtask

  task automatic test_clean_frame;
    p_sel = 1'b1;
    send_frame("clean_55", 7'h55, 1'b0, 1'b1);
    idle(200);
  endtask

  task automatic test_parity_error;
    p_sel = 1'b0;
    send_frame("parity_3a", 7'h3A, 1'b0, 1'b1);
    idle(200);
  endtask

  task automatic test_framing_error;
    p_sel = 1'b1;
    send_frame("frame_12", 7'h12, 1'b0, 1'b0);
    idle(400);
    check_quiet("frame_after");
  endtask

  task automatic test_glitch;
    rx = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch busy_high: got %b, required 1", busy);
    end
    idle(300);
    check_quiet("glitch");
    n_checks++;
    if ({data_out, parity_err, frame_err} !== {last_exp.data, last_exp.perr, last_exp.ferr}) begin
      n_fail++;
      $display("FAIL glitch flags: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
               data_out, parity_err, frame_err, last_exp.data, last_exp.perr, last_exp.ferr);
    end
  endtask

  task automatic test_back_to_back;
    p_sel = 1'b1;
    send_frame("b2b_01", 7'h01, good_par(7'h01, 1'b1), 1'b1);
    send_frame("b2b_7f", 7'h7F, good_par(7'h7F, 1'b1), 1'b1);
    idle(200);
  endtask

  task automatic test_reset_mid_frame;
    logic [6:0] d;
    d = 7'h6C;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx = d[3];
    repeat (BIT_CLK / 2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("reset_mid");
    repeat (5) @(negedge clk);
    rx    = 1'b1;
    reset = 1'b0;
    idle(2000);
    check_quiet("reset_mid_after");
    check_zero("reset_mid_hold");
    p_sel = 1'b1;
    send_frame("after_reset_2b", 7'h2B, good_par(7'h2B, 1'b1), 1'b1);
    idle(200);
  endtask

  initial begin
    test_reset;
    test_clean_frame;
    test_parity_error;
    test_framing_error;
    test_glitch;
    test_back_to_back;
    test_reset_mid_frame;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d pending frames, required 0", exp_q.size());
    end
    check_quiet("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
